alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Parametrised sequencing control unit for the multi-cycle ALU datapath. It accepts a 6-bit MIPS funct code with a start strobe and routes it to the ALU, shifter, multiplier, divider and result mux. It runs MULTU/DIVU for a configurable number of iteration cycles, then issues a one-cycle HiLo write. It replaces the free-running single-op controller with a start/busy/done handshake, per-unit gating and divide support.

## Interface
- WIDTH, 32, operand width; multi-cycle ops iterate exactly WIDTH cycles (WIDTH ≥ 2)
- CNT_W, $clog2(WIDTH), width of iteration counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- funct  in  6  operation code, sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on the last cycle of an operation
- illegal  out  1  one-cycle pulse when start carries an unsupported funct
- iter  out  CNT_W  current iteration index during ITER, else 0
- ctrl_alu  out  6  funct for AND/OR/ADD/SUB/SLT, else 0
- ctrl_sht  out  6  funct for SRL, else 0
- ctrl_mul  out  6  funct for MULTU; 6'b111111 in HILO after MULTU; else 0
- ctrl_div  out  6  funct for DIVU; 6'b111111 in HILO after DIVU; else 0
- ctrl_mux  out  6  latched funct in EXEC/ITER, 6'b111111 in HILO, else 0
- hilo_we  out  1  HiLo register write enable

## Operation
- Codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MFHI 010000, MFLO 010010, MULTU 011001, DIVU 011011. Anything else is illegal.
- States: IDLE, EXEC, ITER, HILO. All outputs are registered.
- IDLE with start and a single-cycle code (ALU, SRL, MFHI, MFLO): latch funct and go to EXEC.
- EXEC: drive the unit controls, assert done, return to IDLE. MFHI/MFLO drive only ctrl_mux.
- IDLE with start and MULTU/DIVU: latch funct, set iter=0, go to ITER.
- ITER: ctrl_mul or ctrl_div and ctrl_mux hold funct. iter increments each cycle. At iter == WIDTH−1, go to HILO.
- HILO: ctrl_mux and the owning unit's control read 6'b111111. Assert hilo_we and done for one cycle, then go to IDLE.
- IDLE with start and an illegal code: pulse illegal the next cycle and stay in IDLE. No done, all controls stay 0.
- start while busy is ignored. funct changes while busy are ignored, because the latched copy is used.
- Counter arithmetic: iter never exceeds WIDTH−1 and does not wrap.

## Timing
- Reset values: state IDLE, all ctrl_* = 0, iter = 0, busy = done = illegal = hilo_we = 0.
- rst wins over every other input in the same cycle.
- rst asserted mid-ITER/HILO returns to IDLE at the next edge with no hilo_we and no done.
- Single-cycle op: start sampled at edge N. EXEC is visible in cycle N+1 with done=1. busy=0 in N+2. Latency 1.
- Multi-cycle op: start at edge N. ITER occupies cycles N+1..N+WIDTH. HILO is in cycle N+WIDTH+1 with hilo_we=done=1. Latency WIDTH+1.
- The next start is accepted in the first IDLE cycle after done. Back-to-back issue spacing is 2 cycles (single) and WIDTH+2 cycles (multi).

## Structure
- Package alu_ctrl_pkg holds:
  - the funct constants listed above
  - HILO_OPEN = 6'b111111
  - the state enum (IDLE, EXEC, ITER, HILO)
  - an op-class decode function (ALU/SHT/MF/MUL/DIV/ILLEGAL)
- Sub-module alu_iter_cnt, parameter WIDTH: a load-zero, enable, terminal-count counter that produces iter and last.
- The top level contains the FSM and the registered output decode.

## Test plan
- Reset: assert rst for 2 cycles → all outputs 0, busy=0.
- ADD: start with 100000 → next cycle ctrl_alu=ctrl_mux=100000, done=1, other controls 0; busy=0 one cycle later.
- MULTU, WIDTH=32:
  - start with 011001 → ctrl_mul=011001 for exactly 32 cycles, iter 0..31.
  - Then one cycle with ctrl_mul=ctrl_mux=111111, hilo_we=done=1.
  - Total busy = 33 cycles.
- DIVU, WIDTH=8: start with 011011 → 8 ITER cycles, then HILO with ctrl_div=111111 and ctrl_mul=0.
- Ignore and reject:
  - start with 100101 mid-MULTU → ignored, MULTU completes unchanged.
  - start with 111000 in IDLE → illegal pulse, busy stays 0, no done.
- Reset mid-operation: rst at iter=10 of MULTU → IDLE next cycle, hilo_we never asserted. A fresh SUB (100010) is then accepted normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the multi-cycle ALU sequencing controller:
//   - MIPS funct codes recognised by the controller
//   - HILO_OPEN, the control word that opens the HiLo path of a unit
//   - the controller state enum
//   - the op-class enum and the decode function that maps a funct onto it
//   - the packed bundle of registered controller outputs
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [5:0] HILO_OPEN = 6'b111111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    HILO
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_SHT,
    CLS_MF,
    CLS_MUL,
    CLS_DIV
  } op_class_t;

  // Every controller output travels together so the whole set can be
  // computed combinationally and captured in one register.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic       hiloWe;
    logic [5:0] ctrlAlu;
    logic [5:0] ctrlSht;
    logic [5:0] ctrlMul;
    logic [5:0] ctrlDiv;
    logic [5:0] ctrlMux;
  } ctrl_out_t;

  // Map a funct code onto the unit that owns it; anything unknown is illegal.
  function automatic op_class_t decodeOp(input logic [5:0] f);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: cls = CLS_ALU;
      FN_SRL:                                cls = CLS_SHT;
      FN_MFHI, FN_MFLO:                      cls = CLS_MF;
      FN_MULTU:                              cls = CLS_MUL;
      FN_DIVU:                               cls = CLS_DIV;
      default:                               cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_iter_cnt.sv
// ---------------------------------------------------------------------------
// alu_iter_cnt
// Iteration counter for the multi-cycle MULTU/DIVU sequence. Counts from 0 up
// to WIDTH-1 and then holds; it never wraps.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, clears the count
//   i_clr   synchronous load-zero
//   i_en    advance the count by one (ignored once the terminal count is hit)
//   o_iter  current count
//   o_last  high when the count equals WIDTH-1
// ---------------------------------------------------------------------------
module alu_iter_cnt #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_iter,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_iter;
  logic             w_last;

  assign w_last = (r_iter == LAST_CNT);

  // Clear has priority over enable; the terminal count is sticky so the
  // counter can never run past WIDTH-1 even if enable stays high.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_iter <= '0;
    end else if (i_en && !w_last) begin
      r_iter <= r_iter + CNT_W'(1);
    end
  end

  assign o_iter = r_iter;
  assign o_last = w_last;

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Sequencing controller for the multi-cycle ALU datapath. A start strobe in
// IDLE latches a funct code; single-cycle ops spend one EXEC cycle, MULTU and
// DIVU iterate WIDTH cycles and then spend one HILO cycle writing HiLo.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request strobe, only looked at in IDLE
//   funct     operation code, sampled together with start
//   busy      high whenever the controller is not IDLE
//   done      one-cycle pulse on the last cycle of an operation
//   illegal   one-cycle pulse after a start with an unsupported funct
//   iter      iteration index while iterating, else 0
//   ctrl_alu  funct for AND/OR/ADD/SUB/SLT during EXEC
//   ctrl_sht  funct for SRL during EXEC
//   ctrl_mul  funct while iterating MULTU, HILO_OPEN in its HILO cycle
//   ctrl_div  funct while iterating DIVU, HILO_OPEN in its HILO cycle
//   ctrl_mux  latched funct in EXEC/ITER, HILO_OPEN in HILO
//   hilo_we   HiLo register write enable
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] iter,
  output logic [5:0]       ctrl_alu,
  output logic [5:0]       ctrl_sht,
  output logic [5:0]       ctrl_mul,
  output logic [5:0]       ctrl_div,
  output logic [5:0]       ctrl_mux,
  output logic             hilo_we
);

  state_t     r_state;
  state_t     w_nextState;
  logic [5:0] r_funct;
  ctrl_out_t  r_out;
  ctrl_out_t  w_nextOut;

  logic [5:0] w_opFunct;
  op_class_t  w_opClass;
  logic       w_accept;
  logic       w_last;
  logic       w_cntClr;
  logic       w_cntEn;

  // In IDLE the live funct is the candidate op; once busy only the latched
  // copy matters, so funct changes during an operation have no effect.
  always_comb begin
    w_opFunct = r_funct;
    if (r_state == IDLE) begin
      w_opFunct = funct;
    end
    w_opClass = decodeOp(w_opFunct);
    w_accept  = (r_state == IDLE) && start && (w_opClass != CLS_ILLEGAL);
  end

  // The counter is held at zero in every cycle that will not be an ITER
  // cycle, so it starts at 0 on entry and reads 0 outside ITER.
  assign w_cntClr = (w_nextState != ITER);
  assign w_cntEn  = (r_state == ITER);

  alu_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cntClr),
    .i_en   (w_cntEn),
    .o_iter (iter),
    .o_last (w_last)
  );

  // State register plus latched funct; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_funct <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_funct <= funct;
      end
    end
  end

  // Next-state logic. Starts are only seen in IDLE; an illegal code keeps
  // the controller in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (w_opClass)
            CLS_MUL, CLS_DIV:        w_nextState = ITER;
            CLS_ALU, CLS_SHT, CLS_MF: w_nextState = EXEC;
            default:                 w_nextState = IDLE;
          endcase
        end
      end
      EXEC: w_nextState = IDLE;
      ITER: begin
        if (w_last) begin
          w_nextState = HILO;
        end
      end
      HILO:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a register
  // that already shows the new state's controls in its first cycle.
  always_comb begin
    w_nextOut         = '0;
    w_nextOut.busy    = (w_nextState != IDLE);
    w_nextOut.illegal = (r_state == IDLE) && start && (w_opClass == CLS_ILLEGAL);
    case (w_nextState)
      EXEC: begin
        w_nextOut.done    = 1'b1;
        w_nextOut.ctrlMux = w_opFunct;
        if (w_opClass == CLS_ALU) begin
          w_nextOut.ctrlAlu = w_opFunct;
        end
        if (w_opClass == CLS_SHT) begin
          w_nextOut.ctrlSht = w_opFunct;
        end
      end
      ITER: begin
        w_nextOut.ctrlMux = w_opFunct;
        if (w_opClass == CLS_MUL) begin
          w_nextOut.ctrlMul = w_opFunct;
        end
        if (w_opClass == CLS_DIV) begin
          w_nextOut.ctrlDiv = w_opFunct;
        end
      end
      HILO: begin
        w_nextOut.done    = 1'b1;
        w_nextOut.hiloWe  = 1'b1;
        w_nextOut.ctrlMux = HILO_OPEN;
        if (w_opClass == CLS_MUL) begin
          w_nextOut.ctrlMul = HILO_OPEN;
        end
        if (w_opClass == CLS_DIV) begin
          w_nextOut.ctrlDiv = HILO_OPEN;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered output bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_nextOut;
    end
  end

  assign busy     = r_out.busy;
  assign done     = r_out.done;
  assign illegal  = r_out.illegal;
  assign hilo_we  = r_out.hiloWe;
  assign ctrl_alu = r_out.ctrlAlu;
  assign ctrl_sht = r_out.ctrlSht;
  assign ctrl_mul = r_out.ctrlMul;
  assign ctrl_div = r_out.ctrlDiv;
  assign ctrl_mux = r_out.ctrlMux;

endmodule
